// File: rtl/chs_video_pkg.sv
// chs_video_pkg: constants and types shared along the video streaming path
package chs_video_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int SOP_BIT = 0;
  localparam int EOP_BIT = 1;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
endpackage

// File: rtl/avalon_st_output_stage.sv
// avalon_st_output_stage: registered Avalon-ST source beat with load/hold/clear
module avalon_st_output_stage
  import chs_video_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  out_ready,
  output logic                  can_load,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop
);
  logic [1:0] mark;
  assign can_load = !out_valid || out_ready;
  assign out_sop = mark[SOP_BIT];
  assign out_eop = mark[EOP_BIT];
  // Take a new beat when the slot is free or being consumed; otherwise hold, retiring a consumed beat
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      mark      <= '0;
    end else if (load && can_load) begin
      out_data      <= in_data;
      mark[SOP_BIT] <= in_sop;
      mark[EOP_BIT] <= in_eop;
      out_valid     <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/avalon_st_frame_arbiter.sv
// avalon_st_frame_arbiter: frame-granular round-robin arbiter for two Avalon-ST pixel streams
module avalon_st_frame_arbiter
  import chs_video_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in0_valid,
  input  logic                  in1_valid,
  input  logic                  in0_sop,
  input  logic                  in0_eop,
  input  logic                  in1_sop,
  input  logic                  in1_eop,
  output logic                  in0_ready,
  output logic                  in1_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready,
  input  logic [1:0]            enable_mask,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  frame_count0,
  output logic [CNT_WIDTH-1:0]  frame_count1,
  output logic [CNT_WIDTH-1:0]  drop_count
);
  arb_state_t state, next;
  logic last_grant, can_load, req0, req1, drain0, drain1, acc0, acc1, load, done0, done1;
  logic [CNT_WIDTH:0] drop_sum;

  assign req0 = enable_mask[0] && in0_valid && in0_sop;
  assign req1 = enable_mask[1] && in1_valid && in1_sop;
  assign drain0 = state == IDLE && enable_mask[0] && in0_valid && !in0_sop;
  assign drain1 = state == IDLE && enable_mask[1] && in1_valid && !in1_sop;
  assign in0_ready = reset && (state == OWN0 ? can_load : drain0);
  assign in1_ready = reset && (state == OWN1 ? can_load : drain1);
  assign acc0 = in0_ready && in0_valid;
  assign acc1 = in1_ready && in1_valid;
  assign load = (state == OWN0 && acc0) || (state == OWN1 && acc1);
  assign done0 = state == OWN0 && acc0 && in0_eop;
  assign done1 = state == OWN1 && acc1 && in1_eop;
  assign drop_sum = {1'b0, drop_count} + (CNT_WIDTH+1)'(drain0) + (CNT_WIDTH+1)'(drain1);

  // Grant per frame; on a tie the input that did not own the last frame wins
  always_comb begin
    next = state;
    if (state == IDLE) next = (req0 && (!req1 || last_grant)) ? OWN0 : req1 ? OWN1 : IDLE;
    else if (done0 || done1) next = IDLE;
  end

  // State, round-robin pointer, grant and counters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= '0;
      frame_count0 <= '0;
      frame_count1 <= '0;
      drop_count   <= '0;
    end else begin
      state <= next;
      grant <= {next == OWN1, next == OWN0};
      if (done0) begin
        last_grant   <= 1'b0;
        frame_count0 <= frame_count0 + 1'b1;
      end
      if (done1) begin
        last_grant   <= 1'b1;
        frame_count1 <= frame_count1 + 1'b1;
      end
      drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

  avalon_st_output_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_data   (state == OWN1 ? in1_data : in0_data),
    .in_sop    (state == OWN1 ? in1_sop : in0_sop),
    .in_eop    (state == OWN1 ? in1_eop : in0_eop),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
  );
endmodule

// File: tb/tb_avalon_st_frame_arbiter.sv
// tb_avalon_st_frame_arbiter: random and directed stimulus checked against a frame-level model
module tb_avalon_st_frame_arbiter;
  localparam int DW = 16;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic in0_valid, in1_valid, in0_sop, in0_eop, in1_sop, in1_eop, in0_ready, in1_ready;
  logic out_valid, out_sop, out_eop, out_ready;
  logic [1:0] enable_mask, grant;
  logic [CW-1:0] frame_count0, frame_count1, drop_count;
  int vectors = 0;
  int miscompares = 0;
  int owner, last, m_drop, fixed_len;
  int m_fc[2];
  bit m_ov, m_sop, m_eop;
  logic [DW-1:0] m_data;
  int pos[2], len[2];
  bit last_acc[2];
  logic [1:0] g_mid, pg;
  logic [1:0] seq[$];
  logic [1:0] cexp[5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  always #5 clk = ~clk;

  avalon_st_frame_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in1_data(in1_data),
    .in0_valid(in0_valid), .in1_valid(in1_valid),
    .in0_sop(in0_sop), .in0_eop(in0_eop), .in1_sop(in1_sop), .in1_eop(in1_eop),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .enable_mask(enable_mask), .grant(grant),
    .frame_count0(frame_count0), .frame_count1(frame_count1), .drop_count(drop_count)
  );

  function automatic bit v(int i);  return i ? in1_valid : in0_valid; endfunction
  function automatic bit sp(int i); return i ? in1_sop : in0_sop; endfunction
  function automatic bit ep(int i); return i ? in1_eop : in0_eop; endfunction
  function automatic logic [DW-1:0] dt(int i); return i ? in1_data : in0_data; endfunction

  // Ready as the arbitration rules define it for the current model state
  function automatic bit exp_ready(int i);
    if (owner == i) return !m_ov || out_ready;
    if (owner < 0) return enable_mask[i] && v(i) && !sp(i);
    return 1'b0;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic mreset();
    owner = -1; last = 1; m_fc = '{0, 0}; m_drop = 0;
    m_ov = 0; m_sop = 0; m_eop = 0; m_data = '0;
  endtask

  task automatic drive(int i, bit vv, bit s, bit e, logic [DW-1:0] d);
    if (i == 0) begin in0_valid = vv; in0_sop = s; in0_eop = e; in0_data = d; end
    else begin in1_valid = vv; in1_sop = s; in1_eop = e; in1_data = d; end
  endtask

  task automatic gen_drive(bit rnd);
    for (int i = 0; i < 2; i++)
      drive(i, rnd ? ($urandom % 4 != 0) : 1'b1, (pos[i] == 0) ^ (rnd && ($urandom % 10 == 0)),
            pos[i] == len[i] - 1, DW'($urandom));
  endtask

  task automatic compare();
    chk("in0_ready", in0_ready, exp_ready(0));
    chk("in1_ready", in1_ready, exp_ready(1));
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_sop", out_sop, m_sop);
      chk("out_eop", out_eop, m_eop);
    end
    chk("grant", grant, owner == 0 ? 1 : owner == 1 ? 2 : 0);
    chk("frame_count0", frame_count0, m_fc[0]);
    chk("frame_count1", frame_count1, m_fc[1]);
    chk("drop_count", drop_count, m_drop);
  endtask

  // One clock of the frame-level model, evaluated on the inputs present at the edge
  task automatic mstep();
    bit a[2], r[2];
    int o;
    for (int i = 0; i < 2; i++) begin
      a[i] = exp_ready(i) && v(i);
      r[i] = enable_mask[i] && v(i) && sp(i);
      last_acc[i] = a[i];
    end
    if (owner < 0) begin
      m_drop += int'(a[0]) + int'(a[1]);
      if (m_drop > 65535) m_drop = 65535;
      if (out_ready) m_ov = 0;
      if (r[0] && r[1]) owner = 1 - last;
      else if (r[0]) owner = 0;
      else if (r[1]) owner = 1;
    end else begin
      o = owner;
      if (a[o]) begin
        m_data = dt(o); m_sop = sp(o); m_eop = ep(o); m_ov = 1;
        if (ep(o)) begin
          owner = -1; last = o; m_fc[o] = (m_fc[o] + 1) % 65536;
        end
      end else if (out_ready) m_ov = 0;
    end
    for (int i = 0; i < 2; i++)
      if (a[i]) begin
        pos[i]++;
        if (pos[i] >= len[i]) begin
          pos[i] = 0;
          len[i] = fixed_len > 0 ? fixed_len : int'($urandom_range(1, 6));
        end
      end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    mstep();
    #1;
  endtask

  task automatic frame(int i, int n, int base);
    int t;
    for (int b = 0; b < n; b++) begin
      drive(i, 1'b1, b == 0, b == n - 1, DW'(base + b));
      t = 0;
      do begin step(); t++; end while (!last_acc[i] && t < 50);
      chk("frame_accept", last_acc[i], 1);
      if (b == 0) g_mid = grant;
    end
    drive(i, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int t, f1;
    mreset();
    fixed_len = 0; pos = '{0, 0}; len = '{3, 3};
    out_ready = 1'b1; enable_mask = 2'b11;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0055);
    drive(1, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_counts", {frame_count0, frame_count1}, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ready", {in0_ready, in1_ready}, 0);
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1 reset = 1'b1;

    frame(0, 4, 1);
    chk("f0_grant_mid", g_mid, 2'b01);
    chk("f0_last_data", out_data, 16'h0004);
    chk("f0_last_eop", out_eop, 1);
    chk("f0_grant_end", grant, 2'b00);
    chk("f0_count", frame_count0, 1);
    step();
    chk("f0_out_idle", out_valid, 0);

    drive(1, 1'b1, 1'b0, 1'b0, 16'h1234);
    #1 chk("orphan_ready", in1_ready, 1);
    step();
    chk("orphan_drop", drop_count, 1);
    chk("orphan_no_out", out_valid, 0);
    drive(1, 1'b0, 1'b0, 1'b0, '0);

    drive(0, 1'b1, 1'b1, 1'b0, 16'h0010); step(); step();
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0011); step();
    out_ready = 1'b0; drive(0, 1'b1, 1'b0, 1'b0, 16'h0012);
    repeat (3) begin
      step();
      chk("bp_hold", out_data, 16'h0011);
      chk("bp_ready", in0_ready, 0);
    end
    out_ready = 1'b1; step();
    chk("bp_resume", out_data, 16'h0012);
    drive(0, 1'b1, 1'b0, 1'b1, 16'h0013); step();
    chk("bp_last", {out_eop, out_data}, {1'b1, 16'h0013});
    chk("bp_count", frame_count0, 2);
    drive(0, 1'b0, 1'b0, 1'b0, '0); step();

    drive(1, 1'b1, 1'b1, 1'b0, 16'h0020); step(); step();
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0021);
    #2 reset = 1'b0;
    mreset();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_counts", {frame_count0, frame_count1, drop_count}, 0);
    chk("mid_rst_ready", in1_ready, 0);
    @(posedge clk); #1 reset = 1'b1;
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0030); step();
    chk("post_rst_grant", grant, 2'b10);
    step();
    drive(1, 1'b1, 1'b0, 1'b1, 16'h0031); step();
    chk("post_rst_count", frame_count1, 1);
    drive(1, 1'b0, 1'b0, 1'b0, '0); step();

    pos = '{0, 0}; len = '{2, 2}; fixed_len = 2;
    pg = grant;
    repeat (12) begin
      gen_drive(1'b0); step();
      if (grant !== pg) begin seq.push_back(grant); pg = grant; end
    end
    while (seq.size() < 5) seq.push_back(2'b11);
    for (int k = 0; k < 5; k++) chk($sformatf("contend_%0d", k), seq[k], cexp[k]);
    t = 0;
    while (owner >= 0 && t < 20) begin gen_drive(1'b0); step(); t++; end
    drive(0, 1'b0, 1'b0, 1'b0, '0); drive(1, 1'b0, 1'b0, 1'b0, '0); step();

    f1 = m_fc[1];
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0040); step();
    chk("mask_grant", grant, 2'b10);
    step();
    enable_mask = 2'b01;
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0041); step();
    drive(1, 1'b1, 1'b0, 1'b1, 16'h0042); step();
    chk("mask_finish", {out_eop, out_data}, {1'b1, 16'h0042});
    chk("mask_count", frame_count1, (f1 + 1) % 65536);
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0050);
    drive(0, 1'b1, 1'b1, 1'b1, 16'h0060); step();
    chk("mask_in0_grant", grant, 2'b01);
    step();
    chk("single_beat", {grant, out_sop, out_eop, out_data}, {2'b00, 1'b1, 1'b1, 16'h0060});
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) begin step(); chk("mask_ignored", grant, 2'b00); end
    drive(1, 1'b0, 1'b0, 1'b0, '0);

    pos = '{0, 0}; len = '{3, 3}; fixed_len = 0; enable_mask = 2'b11;
    repeat (3000) begin
      if ($urandom % 40 == 0) enable_mask = 2'($urandom);
      out_ready = ($urandom % 4 != 0);
      gen_drive(1'b1); step();
    end
    enable_mask = 2'b11; out_ready = 1'b1; t = 0;
    while (owner >= 0 && t < 100) begin gen_drive(1'b0); step(); t++; end
    chk("drain_to_idle", owner < 0, 1);

    drive(0, 1'b1, 1'b0, 1'b0, 16'hAAAA);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h5555);
    repeat (32770) step();
    chk("drop_saturated", drop_count, 16'hFFFF);
    drive(0, 1'b0, 1'b0, 1'b0, '0); step();
    chk("drop_stays_sat", drop_count, 16'hFFFF);
    chk("drop_no_out", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/avalon_st_frame_arbiter.md
# avalon_st_frame_arbiter

Two-input, frame-granular arbiter that shares one 16-bit Avalon-ST video source between two pixel streams. It sits between two upstream Avalon-ST producers and the video IP's streaming source interface. Ownership of the output is granted per frame (startofpacket through endofpacket) in round-robin order, so frames never interleave. The block also drains orphan beats, i.e. data arriving without a leading startofpacket, and exposes per-input frame and drop counters.

## Interface
- `DATA_WIDTH`, 16: pixel word width (RGB565).
- `CNT_WIDTH`, 16: width of the status counters.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in0_data` / `in1_data`  in  DATA_WIDTH  pixel data from each producer.
- `in0_valid` / `in1_valid`  in  1  beat valid.
- `in0_sop`, `in0_eop` / `in1_sop`, `in1_eop`  in  1  frame start and frame end markers.
- `in0_ready` / `in1_ready`  out  1  beat accepted when ready and valid are both high.
- `out_data`  out  DATA_WIDTH  registered output data.
- `out_valid`, `out_sop`, `out_eop`  out  1  registered output valid and markers.
- `out_ready`  in  1  downstream ready (ready latency 0).
- `enable_mask`  in  2  bit i high means input i may be granted.
- `grant`  out  2  one-hot current owner; 00 when IDLE.
- `frame_count0` / `frame_count1`  out  CNT_WIDTH  completed frames forwarded per input; wraps.
- `drop_count`  out  CNT_WIDTH  orphan beats discarded; saturates at all-ones.

## Operation
- The FSM has three states: IDLE, OWN0 and OWN1. `last_grant` is a 1-bit register that resets to 1.
- IDLE, request handling:
  - Input i requests when `enable_mask[i] & in_valid[i] & in_sop[i]`.
  - If one input requests, the next state is OWN<i>.
  - If both request, the input that is not `last_grant` wins.
  - No input is forwarded while in IDLE.
- IDLE, orphan draining:
  - An enabled input with valid high and sop low gets `in_ready[i]` = 1. The beat is discarded and `drop_count` increments.
  - If both inputs drain in the same cycle, `drop_count` adds 2, still saturating.
  - A disabled input gets ready 0 and stalls.
- OWN<i>:
  - `in_ready[i] = !out_valid | out_ready`. The other input's ready is 0.
  - Each accepted beat loads the output register with data, sop and eop, and sets `out_valid` to 1.
  - An accepted beat with eop set causes: next state IDLE, `last_grant` ← i, `frame_count<i>` increments.
  - A beat with sop set in mid-frame is forwarded unchanged and is not treated as a new frame.
- Single-beat frame (sop and eop on the same beat): OWN<i> is held for exactly one cycle, then IDLE.
- Clearing `enable_mask[i]` while in OWN<i> does not abort the frame. It only blocks future grants.
- Output register:
  - Loads when `!out_valid | out_ready`.
  - When no beat is loaded and `out_ready` is high, `out_valid` ← 0.
  - All output fields hold stable while `out_valid & !out_ready`.

## Timing
- Reset values: `out_valid`, `out_sop` and `out_eop` are 0; `out_data` is 0; `grant` is 00; all counters are 0; `in0_ready` and `in1_ready` are 0; state is IDLE.
- Reset assertion clears all of the above immediately and asynchronously, including mid-frame. A partially sent frame is truncated with no eop. Release is synchronous to `clk`.
- Latency is 1 cycle from input acceptance to `out_valid`.
- There is exactly one IDLE bubble cycle between frames, i.e. between the eop acceptance and the first beat of the next frame.
- Throughput is 1 beat/cycle within a frame while `out_ready` is held high.
- `in_ready` is combinational from state, `out_valid` and `out_ready`. There are no combinational paths from `in_valid` to `in_ready` in OWN states.
- `grant` and the counters are registered and update on the edge after the triggering beat.

## Structure
- Shared package `chs_video_pkg`: `DATA_WIDTH` default, the state enum (IDLE/OWN0/OWN1), and sop/eop field positions shared with the rest of the video path.
- One sub-module, `avalon_st_output_stage`: the output register, with load/hold/clear logic and asynchronous active-low reset. It is reusable by other video blocks.
- The top level holds the FSM, `last_grant`, ready generation and the counters.

## Test plan
- **Single frame on in0**: 4 beats 0x0001..0x0004, sop on beat 1, eop on beat 4, `out_ready` = 1. Required: out matches each beat 1 cycle later with sop/eop aligned; `grant` = 01 during the frame, then 00; `frame_count0` = 1.
- **Contention after reset**: both inputs present sop in the same cycle. Required order: in0's frame, one bubble, in1's frame, then in0 again if both retry.
- **Backpressure**: `out_ready` low for 3 cycles mid-frame. Required: `out_data` held constant, owner `in_ready` = 0, no beat lost or duplicated.
- **Orphan beat**: in1 valid with data 0x1234 and sop = 0 while IDLE. Required: `in1_ready` = 1, `out_valid` stays 0, `drop_count` = 1. With `drop_count` preset at all-ones, it remains all-ones.
- **Reset mid-frame**: drive `reset` low on beat 2 of 5. Required: `out_valid`, `grant` and counters go to 0 before the next edge; after release, a fresh sop on in1 is granted normally.
- **Mask change**: clear `enable_mask[1]` during in1's frame. Required: the frame completes with eop and `frame_count1` increments; later in1 sop requests are ignored while in0 still gets grants.
